// File: rtl/sched_pkg.sv
// Shared encodings for the per-frame update scheduler:
// game states, slot indices and sequencer states.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'b00,
    ST_PLAY    = 2'b01,
    ST_HURT    = 2'b10,
    ST_OVER    = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_NEXT   = 2'd3
  } seq_state_e;

  localparam int NUM_SLOTS = 5;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_INPUT  = 3'd0;
  localparam slot_t SLOT_PLAYER = 3'd1;
  localparam slot_t SLOT_DRAGON = 3'd2;
  localparam slot_t SLOT_SHEEP  = 3'd3;
  localparam slot_t SLOT_COLL   = 3'd4;

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(
    input slot_t s
  );
    logic [NUM_SLOTS-1:0] one;
    one = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/sched_slot_timer.sv
// Per-slot done timeout counter.
// Cleared when a strobe goes out, counts wait cycles, saturates at the limit.
module sched_slot_timer #(
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(DONE_TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // next count: clear wins, then count up to the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame entity update sequencer and game-state controller.
// Optional SCHED_DEBUG_EN: seq_cycles reports the last sequence length.
module frame_update_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned DRAGON_DIV   = 8,
  parameter int unsigned HURT_FRAMES  = 60,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_end,
  input  logic                 start_btn,
  input  logic                 player_hurt,
  input  logic [1:0]           player_lives,
  input  logic [NUM_SLOTS-1:0] upd_done,
  output logic [NUM_SLOTS-1:0] upd_strobe,
  output logic                 busy,
  output logic [1:0]           game_state,
  output logic                 freeze,
  output logic [7:0]           frame_cnt,
  output logic [7:0]           overrun_cnt,
  output logic [NUM_SLOTS-1:0] timeout_flags,
  output logic [15:0]          seq_cycles
);

  localparam logic [7:0] DIV_MASK  = 8'(DRAGON_DIV - 1);
  localparam logic [7:0] HURT_LAST = 8'(HURT_FRAMES - 1);
  localparam logic [7:0] OVER_LAST = 8'(OVER_FRAMES - 1);

  seq_state_e           seq_q, seq_d;
  slot_t                slot_q, slot_d;
  game_state_e          gs_q, gs_d;
  logic [7:0]           fcnt_q, fcnt_d;
  logic [7:0]           ovr_q, ovr_d;
  logic [7:0]           phase_q, phase_d;
  logic [NUM_SLOTS-1:0] flags_q, flags_d;
  logic [NUM_SLOTS-1:0] strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 freeze_q, freeze_d;
  logic                 hurt_pend_q, hurt_pend_d;

  logic seq_end;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;
  logic skip_dragon;
  logic hurt_eval;

  sched_slot_timer #(
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  assign skip_dragon = ((fcnt_q & DIV_MASK) != 8'd0);

  // sequencer and game-state next-state logic
  always_comb begin
    seq_d       = seq_q;
    slot_d      = slot_q;
    gs_d        = gs_q;
    fcnt_d      = fcnt_q;
    ovr_d       = ovr_q;
    phase_d     = phase_q;
    flags_d     = flags_q;
    hurt_pend_d = hurt_pend_q | player_hurt;
    seq_end     = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    hurt_eval   = 1'b0;

    unique case (seq_q)
      S_IDLE: begin
        if (frame_end && (gs_q == ST_PLAY)
            && !hurt_pend_q) begin
          seq_d  = S_STROBE;
          slot_d = SLOT_INPUT;
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      S_STROBE: begin
        seq_d   = S_WAIT;
        tmr_clr = 1'b1;
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        if (upd_done[slot_q]) begin
          seq_d = S_NEXT;
        end else if (tmr_exp) begin
          flags_d[slot_q] = 1'b1;
          seq_d           = S_NEXT;
        end
      end
      S_NEXT: begin
        if (slot_q == SLOT_COLL) begin
          seq_d   = S_IDLE;
          seq_end = 1'b1;
        end else begin
          slot_d = slot_q + 3'd1;
          if ((slot_d == SLOT_DRAGON) && skip_dragon) begin
            seq_d = S_NEXT;
          end else begin
            seq_d = S_STROBE;
          end
        end
      end
    endcase

    if (frame_end && (seq_q != S_IDLE)
        && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    hurt_eval = hurt_pend_q
              && (seq_end
                  || (frame_end && (seq_q == S_IDLE)));

    unique case (gs_q)
      ST_ATTRACT: begin
        if (frame_end && start_btn) begin
          gs_d        = ST_PLAY;
          fcnt_d      = '0;
          flags_d     = '0;
          hurt_pend_d = player_hurt;
        end
      end
      ST_PLAY: begin
        if (hurt_eval) begin
          gs_d        = (player_lives == 2'd0)
                      ? ST_OVER : ST_HURT;
          hurt_pend_d = player_hurt;
          phase_d     = '0;
        end
      end
      ST_HURT: begin
        hurt_pend_d = 1'b0;
        if (frame_end) begin
          if (phase_q == HURT_LAST) begin
            gs_d = ST_PLAY;
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (frame_end) begin
          if (phase_q == OVER_LAST) begin
            gs_d = ST_ATTRACT;
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
      end
    endcase

    busy_d   = (seq_d != S_IDLE);
    freeze_d = (gs_d != ST_PLAY);
    strobe_d = (seq_d == S_STROBE)
             ? slot_onehot(slot_d) : '0;
  end

  // state registers; reset aborts any running sequence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q       <= S_IDLE;
      slot_q      <= SLOT_INPUT;
      gs_q        <= ST_ATTRACT;
      fcnt_q      <= '0;
      ovr_q       <= '0;
      phase_q     <= '0;
      flags_q     <= '0;
      strobe_q    <= '0;
      busy_q      <= 1'b0;
      freeze_q    <= 1'b0;
      hurt_pend_q <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      slot_q      <= slot_d;
      gs_q        <= gs_d;
      fcnt_q      <= fcnt_d;
      ovr_q       <= ovr_d;
      phase_q     <= phase_d;
      flags_q     <= flags_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      freeze_q    <= freeze_d;
      hurt_pend_q <= hurt_pend_d;
    end
  end

  assign upd_strobe    = strobe_q;
  assign busy          = busy_q;
  assign game_state    = gs_q;
  assign freeze        = freeze_q;
  assign frame_cnt     = fcnt_q;
  assign overrun_cnt   = ovr_q;
  assign timeout_flags = flags_q;

`ifdef SCHED_DEBUG_EN
  logic [15:0] dcnt_q, dcnt_d;
  logic [15:0] seqc_q, seqc_d;

  // busy-cycle counter, latched when busy falls
  always_comb begin
    dcnt_d = dcnt_q;
    seqc_d = seqc_q;
    if (busy_q) begin
      if (dcnt_q != 16'hFFFF) begin
        dcnt_d = dcnt_q + 16'd1;
      end
      if (!busy_d) begin
        seqc_d = (dcnt_q == 16'hFFFF)
               ? 16'hFFFF : dcnt_q + 16'd1;
      end
    end else begin
      dcnt_d = '0;
    end
  end

  // debug registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt_q <= '0;
      seqc_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      seqc_q <= seqc_d;
    end
  end

  assign seq_cycles = seqc_q;
`else
  assign seq_cycles = '0;
`endif

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Per-frame update sequencer and game-state controller for the game datapath.
- On each frame_end it issues one-cycle update strobes, in fixed order, to the entity logic: input collector, player, dragon, sheep, collision. Each slot is closed by a done handshake or a timeout.
- Owns the top-level game state (ATTRACT/PLAY/HURT/OVER) and the freeze signal that pauses entity logic during hurt and game-over phases.

Parameters:
- DRAGON_DIV, 8: dragon slot is issued only on frames where frame_cnt mod DRAGON_DIV == 0 (power of two, 1..128).
- HURT_FRAMES, 60: frames spent in HURT before returning to PLAY (1..255).
- OVER_FRAMES, 180: frames spent in OVER before returning to ATTRACT (1..255).
- DONE_TIMEOUT, 255: cycles after a strobe to wait for done before abandoning the slot (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- frame_end  in  1  one-cycle pulse from the sync generator
- start_btn  in  1  level; start request (attack button)
- player_hurt  in  1  one-cycle pulse from the hearts block
- player_lives  in  2  remaining lives
- upd_done  in  5  per-slot completion pulse; bit i belongs to slot i
- upd_strobe  out  5  one-hot, one-cycle update strobe; 0 input, 1 player, 2 dragon, 3 sheep, 4 collision
- busy  out  1  sequence in progress
- game_state  out  2  00 ATTRACT, 01 PLAY, 10 HURT, 11 OVER
- freeze  out  1  high in every state except PLAY
- frame_cnt  out  8  PLAY frames counted; wraps 255->0
- overrun_cnt  out  8  dropped frames; saturates at 255
- timeout_flags  out  5  sticky per-slot timeout flags
- seq_cycles  out  16  debug measurement (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge) sets every output to 0 and game_state to ATTRACT. A reset mid-sequence aborts the sequence immediately; no further strobe is issued.
- Sequencer FSM states: S_IDLE, S_STROBE, S_WAIT, S_NEXT.
- Starting a sequence:
  - frame_end while S_IDLE and game_state==PLAY starts a sequence at slot 0.
  - busy rises in the cycle after frame_end.
  - frame_cnt increments in the same cycle the sequence starts.
- S_STROBE: assert upd_strobe[slot] for exactly one cycle, then go to S_WAIT with the timeout counter cleared.
- S_WAIT:
  - upd_done[slot]=1 goes to S_NEXT.
  - If the counter reaches DONE_TIMEOUT first, set timeout_flags[slot] and go to S_NEXT.
  - upd_done bits for slots other than the current one are ignored.
  - A done that arrives in the same cycle as its strobe is not accepted; it must arrive at least one cycle later.
- S_NEXT: slot++. Slot 2 is skipped when frame_cnt mod DRAGON_DIV != 0; a skip costs one cycle and issues no strobe. After slot 4, return to S_IDLE and deassert busy.
- Minimum sequence length with immediate done responses: 3 cycles per slot.
- Overrun: frame_end while busy is dropped and overrun_cnt increments. The running sequence continues.
- player_hurt is latched into hurt_pend in any state. In PLAY it is evaluated when the sequence ends (or at frame_end if not busy):
  - player_lives==0 goes to OVER.
  - Otherwise go to HURT.
  - hurt_pend is cleared on either transition.
- Game-state transitions:
  - ATTRACT->PLAY: frame_end with start_btn=1. frame_cnt clears to 0 and timeout_flags clear.
  - HURT: a frame counter runs on frame_end. After HURT_FRAMES frames, go to PLAY. hurt_pend received during HURT is discarded.
  - OVER: after OVER_FRAMES frames, go to ATTRACT. start_btn is ignored while in OVER.
- No strobes are issued outside PLAY.
- freeze is registered and updates in the same cycle as game_state.

Optional Feature:
- Macro: SCHED_DEBUG_EN.
- Defined: seq_cycles holds the cycle count of the last completed sequence, from busy rising to busy falling inclusive, saturating at 16'hFFFF. It updates when busy falls.
- Undefined: seq_cycles is tied to 0 and its counter logic is absent.

Decomposition:
- Package sched_pkg holds:
  - game-state encodings ST_ATTRACT/ST_PLAY/ST_HURT/ST_OVER;
  - slot indices SLOT_INPUT..SLOT_COLL and NUM_SLOTS=5;
  - sequencer state encodings.
- Sub-module sched_slot_timer: 8-bit timeout counter with clear, enable, and expired output (==DONE_TIMEOUT).

Test Plan:
- Reset, then frame_end with start_btn=1 -> game_state=01, freeze=0, frame_cnt=0, no strobe in that frame.
- PLAY; frame_end with done returned 1 cycle after each strobe, frame_cnt a multiple of 8 -> strobes 00001, 00010, 00100, 01000, 10000 in order, 3 cycles apart; busy high for 15 cycles.
- PLAY, frame_cnt=3 -> slot 2 skipped with no strobe; the remaining four slots are strobed; busy high for 13 cycles.
- upd_done[1] never asserted, DONE_TIMEOUT=255 -> timeout_flags=00010 after 255 wait cycles; slot 2 or 3 is strobed next; the flag stays set.
- frame_end during busy -> overrun_cnt 0->1; no restart; the next frame_end after busy falls starts a sequence normally.
- player_hurt with lives=2 mid-sequence -> HURT at sequence end, freeze=1, PLAY after 60 frame_ends. player_hurt with lives=0 -> OVER, start_btn ignored, ATTRACT after 180 frames.
